// File: rtl/fir_sample_feeder_pkg.sv
// rtl/fir_sample_feeder_pkg.sv - shared FIR constants and feeder FSM encoding
// Purpose: single source for the FIR sample width and frame length so the
//          feeder and the FIR core agree on cadence; also the feeder state type.
// Ports:   none (package).
package fir_pkg;

   localparam int FIR_DATA_WIDTH   = 8;
   localparam int FIR_FRAME_CYCLES = 9;   // IDLE + LOAD + 6 x MAC + STORE

   typedef enum logic {
      ST_FILL = 1'b0,
      ST_RUN  = 1'b1
   } feed_state_e;

endpackage

// File: rtl/fir_sample_feeder_if.sv
// rtl/fir_sample_feeder_if.sv - valid/ready sample stream into the feeder
// Purpose: bundles the source-side handshake of the sample feeder.
// Ports:   s_valid (source -> feeder), s_data (source -> feeder),
//          s_ready (feeder -> source).
interface fir_sample_feeder_if #(
   parameter int DATA_WIDTH = 8
);

   logic                  s_valid;
   logic [DATA_WIDTH-1:0] s_data;
   logic                  s_ready;

   modport master (output s_valid, output s_data, input  s_ready);
   modport slave  (input  s_valid, input  s_data, output s_ready);

endinterface

// File: rtl/fir_sample_feeder_sync_fifo.sv
// rtl/fir_sample_feeder_sync_fifo.sv - single-clock FIFO with occupancy count
// Purpose: registered storage between the bursty source and the frame-paced pop.
// Ports:   clk, rst (sync, active-high); wr_en_i/wr_data_i write port;
//          rd_en_i pops the head; rd_data_o is the current head (combinational);
//          count_o occupancy 0..DEPTH; full_o/empty_o status.
module sync_fifo #(
   parameter  int DATA_WIDTH = 8,
   parameter  int DEPTH      = 16,
   localparam int AW         = $clog2(DEPTH)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  wr_en_i,
   input  logic [DATA_WIDTH-1:0] wr_data_i,
   input  logic                  rd_en_i,
   output logic [DATA_WIDTH-1:0] rd_data_o,
   output logic [AW:0]           count_o,
   output logic                  full_o,
   output logic                  empty_o
);

   logic [DATA_WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]         wr_ptr_q, rd_ptr_q;
   logic [AW:0]           count_q;
   logic                  wr_ok, rd_ok;

   assign full_o    = (count_q == (AW+1)'(DEPTH));
   assign empty_o   = (count_q == '0);
   assign count_o   = count_q;
   assign rd_data_o = mem_q[rd_ptr_q];

   // Requests against a full/empty FIFO are dropped rather than corrupting state.
   assign wr_ok = wr_en_i && !full_o;
   assign rd_ok = rd_en_i && !empty_o;

   always_ff @(posedge clk) begin
      if (wr_ok) begin
         mem_q[wr_ptr_q] <= wr_data_i;
      end
   end

   // Pointers are exactly AW bits so they wrap on their own at DEPTH.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (wr_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
         if (rd_ok) rd_ptr_q <= rd_ptr_q + AW'(1);
         case ({wr_ok, rd_ok})
            2'b10:   count_q <= count_q + (AW+1)'(1);
            2'b01:   count_q <= count_q - (AW+1)'(1);
            default: count_q <= count_q;
         endcase
      end
   end

endmodule

// File: rtl/fir_sample_feeder.sv
// rtl/fir_sample_feeder.sv - converts a bursty sample stream to one sample per FIR frame
// Purpose: buffers source samples and presents exactly one on fir_data every
//          FRAME_CYCLES clocks once the FIFO has been primed.
// Ports:   clk, rst (sync, active-high); s_if (slave side of the sample stream,
//          s_ready = !full && !rst); clr_flags clears underflow_flag;
//          fir_data registered FIR input; sample_tick pulses when fir_data updates;
//          fill_count FIFO occupancy; underflow_flag sticky empty-at-tick indicator.
module fir_sample_feeder
   import fir_pkg::*;
#(
   parameter  int DATA_WIDTH    = FIR_DATA_WIDTH,
   parameter  int DEPTH         = 16,
   parameter  int FRAME_CYCLES  = FIR_FRAME_CYCLES,
   parameter  int PRIME_LEVEL   = 4,
   parameter  bit ZERO_ON_EMPTY = 1'b1,
   localparam int CW            = $clog2(DEPTH) + 1,
   localparam int FW            = $clog2(FRAME_CYCLES)
) (
   input  logic                  clk,
   input  logic                  rst,
   fir_sample_feeder_if.slave    s_if,
   input  logic                  clr_flags,
   output logic [DATA_WIDTH-1:0] fir_data,
   output logic                  sample_tick,
   output logic [CW-1:0]         fill_count,
   output logic                  underflow_flag
);

   feed_state_e           state_q, state_d;
   logic [FW-1:0]         frame_cnt_q, frame_cnt_d;
   logic [DATA_WIDTH-1:0] fir_data_q, fir_data_d;
   logic                  sample_tick_q, sample_tick_d;
   logic                  flag_q, flag_d;
   logic                  tick, pop, underflow;
   logic                  fifo_full, fifo_empty;
   logic [DATA_WIDTH-1:0] fifo_head;
   logic [CW-1:0]         fifo_count;

   assign s_if.s_ready = !fifo_full && !rst;

   sync_fifo #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .wr_en_i   (s_if.s_valid && s_if.s_ready),
      .wr_data_i (s_if.s_data),
      .rd_en_i   (pop),
      .rd_data_o (fifo_head),
      .count_o   (fifo_count),
      .full_o    (fifo_full),
      .empty_o   (fifo_empty)
   );

   // Free-running frame phase; it runs in FILL too so the FIR cadence never slips.
   assign tick        = (frame_cnt_q == FW'(FRAME_CYCLES - 1));
   assign frame_cnt_d = tick ? '0 : frame_cnt_q + FW'(1);

   always_comb begin
      state_d       = state_q;
      fir_data_d    = fir_data_q;
      sample_tick_d = 1'b0;
      pop           = 1'b0;
      underflow     = 1'b0;
      case (state_q)
         ST_FILL: begin
            if (fifo_count >= CW'(PRIME_LEVEL)) state_d = ST_RUN;
         end
         ST_RUN: begin
            // Only the registered occupancy decides the pop, so a push landing
            // on the same tick edge cannot rescue an empty FIFO.
            if (tick) begin
               sample_tick_d = 1'b1;
               if (!fifo_empty) begin
                  pop        = 1'b1;
                  fir_data_d = fifo_head;
               end else begin
                  underflow = 1'b1;
                  if (ZERO_ON_EMPTY) fir_data_d = '0;
               end
            end
         end
         default: state_d = ST_FILL;
      endcase
      // Setting beats clearing when both arrive on the same edge.
      flag_d = underflow ? 1'b1 : (clr_flags ? 1'b0 : flag_q);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= ST_FILL;
         frame_cnt_q   <= '0;
         fir_data_q    <= '0;
         sample_tick_q <= 1'b0;
         flag_q        <= 1'b0;
      end else begin
         state_q       <= state_d;
         frame_cnt_q   <= frame_cnt_d;
         fir_data_q    <= fir_data_d;
         sample_tick_q <= sample_tick_d;
         flag_q        <= flag_d;
      end
   end

   assign fir_data       = fir_data_q;
   assign sample_tick    = sample_tick_q;
   assign fill_count     = fifo_count;
   assign underflow_flag = flag_q;

endmodule

// File: tb/tb_fir_sample_feeder.sv
// tb/tb_fir_sample_feeder.sv - self-checking bench for fir_sample_feeder
module tb_fir_sample_feeder;
   import fir_pkg::*;

   localparam int DW    = 8;
   localparam int DEPTH = 16;
   localparam int FC    = FIR_FRAME_CYCLES;
   localparam int PRIME = 4;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          rst, s_valid, clr_flags;
   logic [DW-1:0] s_data;

   fir_sample_feeder_if #(.DATA_WIDTH(DW)) if_a ();
   fir_sample_feeder_if #(.DATA_WIDTH(DW)) if_b ();
   assign if_a.s_valid = s_valid;
   assign if_a.s_data  = s_data;
   assign if_b.s_valid = s_valid;
   assign if_b.s_data  = s_data;

   logic [DW-1:0] fa_data, fb_data;
   logic          fa_tick, fb_tick, fa_flag, fb_flag;
   logic [4:0]    fa_fill, fb_fill;

   // a: zero on underflow, b: hold last sample on underflow
   fir_sample_feeder #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .FRAME_CYCLES(FC),
                       .PRIME_LEVEL(PRIME), .ZERO_ON_EMPTY(1'b1)) dut_a (
      .clk(clk), .rst(rst), .s_if(if_a), .clr_flags(clr_flags),
      .fir_data(fa_data), .sample_tick(fa_tick), .fill_count(fa_fill),
      .underflow_flag(fa_flag));

   fir_sample_feeder #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .FRAME_CYCLES(FC),
                       .PRIME_LEVEL(PRIME), .ZERO_ON_EMPTY(1'b0)) dut_b (
      .clk(clk), .rst(rst), .s_if(if_b), .clr_flags(clr_flags),
      .fir_data(fb_data), .sample_tick(fb_tick), .fill_count(fb_fill),
      .underflow_flag(fb_flag));

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string name, input int act, input int exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Behavioural model: a sample queue plus a cycle count since reset.
   logic [DW-1:0] m_q[$];
   int            m_cyc   = 0;
   bit            m_run   = 0;
   bit            m_tick  = 0;
   bit            m_flag  = 0;
   bit            m_valid = 0;
   logic [DW-1:0] m_fir_a = '0;
   logic [DW-1:0] m_fir_b = '0;

   always @(posedge clk) begin
      int pre;
      bit push, uf;
      pre  = m_q.size();
      push = s_valid && !rst && (pre < DEPTH);
      if (rst) begin
         m_q.delete();
         m_cyc = 0; m_run = 0; m_tick = 0; m_flag = 0;
         m_fir_a = '0; m_fir_b = '0;
      end else begin
         m_tick = m_run && ((m_cyc % FC) == FC - 1);
         uf     = m_tick && (pre == 0);
         if (m_tick && pre > 0) begin
            m_fir_a = m_q.pop_front();
            m_fir_b = m_fir_a;
         end else if (uf) begin
            m_fir_a = '0;
         end
         if (uf) m_flag = 1;
         else if (clr_flags) m_flag = 0;
         if (!m_run && pre >= PRIME) m_run = 1;
         if (push) m_q.push_back(s_data);
         m_cyc++;
      end
      m_valid = 1;
   end

   always @(negedge clk) begin
      if (m_valid) begin
         check("m_fir_a", int'(fa_data), int'(m_fir_a));
         check("m_fir_b", int'(fb_data), int'(m_fir_b));
         check("m_tick",  int'(fa_tick), int'(m_tick));
         check("m_fill",  int'(fa_fill), m_q.size());
         check("m_flag",  int'(fa_flag), int'(m_flag));
         check("m_ready", int'(if_a.s_ready), int'(!rst && m_q.size() < DEPTH));
         check("m_ready_b", int'(if_b.s_ready), int'(if_a.s_ready));
      end
   end

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [DW-1:0] v);
      s_valid = 1'b1;
      s_data  = v;
      step(1);
      s_valid = 1'b0;
   endtask

   task automatic wait_tick(output int n);
      n = 0;
      do begin
         step(1);
         n++;
      end while (!fa_tick && n < 40);
      if (!fa_tick) check("wait_tick_timeout", 0, 1);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      logic [DW-1:0] exp_seq [4];
      exp_seq[0] = 8'h11; exp_seq[1] = 8'h22; exp_seq[2] = 8'h33; exp_seq[3] = 8'h44;
      rst = 1'b1; s_valid = 1'b1; s_data = 8'hAA; clr_flags = 1'b0;

      // Reset with s_valid asserted
      step(3);
      check("rst_s_ready", int'(if_a.s_ready), 0);
      check("rst_fill", int'(fa_fill), 0);
      check("rst_fir", int'(fa_data), 0);
      rst = 1'b0; s_valid = 1'b0;

      // Priming
      push(8'h11); push(8'h22); push(8'h33);
      check("prime_fill3", int'(fa_fill), 3);
      check("prime_fir0", int'(fa_data), 0);
      push(8'h44);
      check("prime_fill4", int'(fa_fill), 4);
      wait_tick(n);
      check("first_tick_delay", n, 5);
      check("first_sample", int'(fa_data), int'(exp_seq[0]));
      for (int i = 1; i < 4; i++) begin
         wait_tick(n);
         check("tick_spacing", n, 9);
         check("sample_seq", int'(fa_data), int'(exp_seq[i]));
      end

      // Underflow after draining
      wait_tick(n);
      check("uf_spacing", n, 9);
      check("uf_flag", int'(fa_flag), 1);
      check("uf_zero", int'(fa_data), 0);
      check("uf_hold", int'(fb_data), 8'h44);
      clr_flags = 1'b1;
      step(1);
      clr_flags = 1'b0;
      check("clr_flag", int'(fa_flag), 0);

      // Push on the tick edge with the FIFO empty
      step(7);
      s_valid = 1'b1; s_data = 8'h55;
      step(1);
      s_valid = 1'b0;
      check("edge_push_tick", int'(fa_tick), 1);
      check("edge_push_uf", int'(fa_flag), 1);
      check("edge_push_fir", int'(fa_data), 0);
      check("edge_push_fill", int'(fa_fill), 1);
      wait_tick(n);
      check("edge_push_spacing", n, 9);
      check("edge_push_out", int'(fa_data), 8'h55);

      // Push and pop on the same edge with five entries
      s_valid = 1'b1;
      for (int k = 0; k < 5; k++) begin
         s_data = 8'h61 + 8'(k);
         step(1);
      end
      s_valid = 1'b0;
      check("pp_fill_before", int'(fa_fill), 5);
      step(3);
      s_valid = 1'b1; s_data = 8'h66;
      step(1);
      s_valid = 1'b0;
      check("pp_tick", int'(fa_tick), 1);
      check("pp_fill", int'(fa_fill), 5);
      check("pp_fir", int'(fa_data), 8'h61);

      // Full FIFO, no bypass while full
      rst = 1'b1;
      step(1);
      check("rst2_ready", int'(if_a.s_ready), 0);
      rst = 1'b0; s_valid = 1'b1; s_data = 8'h80;
      n = 0;
      do begin
         step(1);
         s_data = s_data + 8'd1;
         n++;
      end while (fa_fill != 5'd16 && n < 40);
      check("full_fill", int'(fa_fill), 16);
      check("full_cycles", n, 17);
      check("full_ready", int'(if_a.s_ready), 0);
      step(1);
      s_valid = 1'b0;
      check("full_pop_fill", int'(fa_fill), 15);
      check("full_pop_ready", int'(if_a.s_ready), 1);
      check("full_pop_tick", int'(fa_tick), 1);
      check("full_pop_fir", int'(fa_data), 8'h81);

      // Reset mid-RUN with seven entries
      rst = 1'b1;
      step(1);
      rst = 1'b0; s_valid = 1'b1;
      for (int k = 0; k < 8; k++) begin
         s_data = 8'hC1 + 8'(k);
         step(1);
      end
      s_valid = 1'b0;
      step(1);
      check("mid_fill7", int'(fa_fill), 7);
      check("mid_fir", int'(fa_data), 8'hC1);
      rst = 1'b1;
      step(1);
      check("mid_rst_fill", int'(fa_fill), 0);
      check("mid_rst_fir", int'(fa_data), 0);
      check("mid_rst_tick", int'(fa_tick), 0);
      check("mid_rst_ready", int'(if_a.s_ready), 0);
      rst = 1'b0;
      step(30);
      check("post_rst_fir_a", int'(fa_data), 0);
      check("post_rst_fir_b", int'(fb_data), 0);
      check("post_rst_flag", int'(fa_flag), 0);
      check("post_rst_fill", int'(fa_fill), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
